// File: rtl/fwd_pkg.sv
// Shared types for the forwarding/hazard unit: forward-select codes
// and the per-stage destination tag carried through EX, MEM and WB.
package fwd_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  // Tag address width; narrower register files are zero-extended into it.
  localparam int TAG_AW = 8;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic              is_load;
    logic [TAG_AW-1:0] dst;
  } fwd_tag_t;

  function automatic logic tag_hit(
    input fwd_tag_t          t,
    input logic [TAG_AW-1:0] a
  );
    return t.valid && t.we && (t.dst == a) && (a != '0);
  endfunction

endpackage

// File: rtl/fwd_stage_reg.sv
// Async-reset tag register with load and bubble control.
// Bubble has priority over load and clears the entry.
module fwd_stage_reg #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         bubble_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (bubble_i) begin
      q_d = '0;
    end else if (load_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use stall for the 16-bit pipeline.
// Define FWD_WB_BYPASS_EN to enable WB-stage forwarding (1-cycle load-use).
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 3,
  parameter int NUM_SRC = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]         id_dst_addr,
  input  logic                      id_dst_we,
  input  logic                      id_is_load,
  input  logic                      flush,
  input  logic [DATA_W-1:0]         mem_data,
  input  logic [DATA_W-1:0]         wb_data,
  output logic                      stall,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic [NUM_SRC-1:0]        fwd_valid,
  output logic [NUM_SRC*DATA_W-1:0] fwd_data
);

  localparam int TW = $bits(fwd_tag_t);
  localparam int SW = NUM_SRC * (REG_AW + 1);

  fwd_tag_t id_tag;
  fwd_tag_t ex_q;
  fwd_tag_t mem_q;
  fwd_tag_t wb_q;

  logic [NUM_SRC-1:0]        ex_used;
  logic [NUM_SRC*REG_AW-1:0] ex_addr;
  logic                      ex_load;

  assign id_tag = '{
    valid:   id_valid,
    we:      id_dst_we,
    is_load: id_is_load,
    dst:     TAG_AW'(id_dst_addr)
  };

  assign ex_load = id_valid && !stall && !flush;

  fwd_stage_reg #(.W(TW)) u_ex (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .load_i   (ex_load),
    .bubble_i (!ex_load),
    .d_i      (id_tag),
    .q_o      (ex_q)
  );

  fwd_stage_reg #(.W(SW)) u_ex_src (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .load_i   (ex_load),
    .bubble_i (!ex_load),
    .d_i      ({id_src_used, id_src_addr}),
    .q_o      ({ex_used, ex_addr})
  );

  fwd_stage_reg #(.W(TW)) u_mem (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .load_i   (1'b1),
    .bubble_i (1'b0),
    .d_i      (ex_q),
    .q_o      (mem_q)
  );

  fwd_stage_reg #(.W(TW)) u_wb (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .load_i   (1'b1),
    .bubble_i (1'b0),
    .d_i      (mem_q),
    .q_o      (wb_q)
  );

  // Without WB bypass a load in MEM is still too young for the RF read.
  always_comb begin
    stall = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_valid && id_src_used[i]) begin
        if (ex_q.is_load &&
            tag_hit(ex_q, TAG_AW'(id_src_addr[i*REG_AW +: REG_AW]))) begin
          stall = 1'b1;
        end
`ifndef FWD_WB_BYPASS_EN
        if (mem_q.is_load &&
            tag_hit(mem_q, TAG_AW'(id_src_addr[i*REG_AW +: REG_AW]))) begin
          stall = 1'b1;
        end
`endif
      end
    end
  end

  always_comb begin
    fwd_sel   = '0;
    fwd_valid = '0;
    fwd_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ex_q.valid && ex_used[i]) begin
        if (!mem_q.is_load &&
            tag_hit(mem_q, TAG_AW'(ex_addr[i*REG_AW +: REG_AW]))) begin
          fwd_sel[2*i +: 2]       = FWD_MEM;
          fwd_data[i*DATA_W +: DATA_W] = mem_data;
        end
`ifdef FWD_WB_BYPASS_EN
        else if (tag_hit(wb_q, TAG_AW'(ex_addr[i*REG_AW +: REG_AW]))) begin
          fwd_sel[2*i +: 2]       = FWD_WB;
          fwd_data[i*DATA_W +: DATA_W] = wb_data;
        end
`endif
      end
      fwd_valid[i] = |fwd_sel[2*i +: 2];
    end
  end

  logic unused_wb;
`ifdef FWD_WB_BYPASS_EN
  assign unused_wb = wb_q.is_load;
`else
  assign unused_wb = ^{wb_q, wb_data};
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit, covering both FWD_WB_BYPASS_EN builds.
// Expected values are hand-computed per scenario.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [5:0]  id_src_addr;
  logic [1:0]  id_src_used;
  logic [2:0]  id_dst_addr;
  logic        id_dst_we;
  logic        id_is_load;
  logic        flush;
  logic [15:0] mem_data;
  logic [15:0] wb_data;
  logic        stall;
  logic [3:0]  fwd_sel;
  logic [1:0]  fwd_valid;
  logic [31:0] fwd_data;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(
    .DATA_W  (16),
    .REG_AW  (3),
    .NUM_SRC (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_src_addr (id_src_addr),
    .id_src_used (id_src_used),
    .id_dst_addr (id_dst_addr),
    .id_dst_we   (id_dst_we),
    .id_is_load  (id_is_load),
    .flush       (flush),
    .mem_data    (mem_data),
    .wb_data     (wb_data),
    .stall       (stall),
    .fwd_sel     (fwd_sel),
    .fwd_valid   (fwd_valid),
    .fwd_data    (fwd_data)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] s0, input logic [2:0] s1,
                       input logic [1:0] used, input logic [2:0] dst,
                       input logic we, input logic ld);
    id_valid    = 1'b1;
    id_src_addr = {s1, s0};
    id_src_used = used;
    id_dst_addr = dst;
    id_dst_we   = we;
    id_is_load  = ld;
  endtask

  task automatic idle();
    id_valid    = 1'b0;
    id_src_addr = '0;
    id_src_used = '0;
    id_dst_addr = '0;
    id_dst_we   = 1'b0;
    id_is_load  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b1;
    flush    = 1'b0;
    mem_data = '0;
    wb_data  = '0;
    idle();
    #2 rst_n = 1'b0;
    #2;
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_sel", 32'(fwd_sel), 32'h0);
    check("rst_valid", 32'(fwd_valid), 32'h0);
    check("rst_data", fwd_data, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // first instruction after reset
    issue(3'd3, 3'd0, 2'b01, 3'd3, 1'b1, 1'b0);
    step();
    check("first_sel", 32'(fwd_sel), 32'h0);

    // ALU back-to-back on r3
    issue(3'd3, 3'd0, 2'b01, 3'd7, 1'b1, 1'b0);
    #1 check("b2b_nostall", 32'(stall), 32'h0);
    step();
    idle();
    mem_data = 16'h1234;
    #1;
    check("b2b_sel", 32'(fwd_sel), 32'h1);
    check("b2b_data", fwd_data, 32'h0000_1234);
    check("b2b_valid", 32'(fwd_valid), 32'h1);

    // distance-2 on r5 via src1
    issue(3'd0, 3'd0, 2'b00, 3'd5, 1'b1, 1'b0);
    step();
    issue(3'd0, 3'd0, 2'b00, 3'd1, 1'b1, 1'b0);
    step();
    issue(3'd0, 3'd5, 2'b10, 3'd7, 1'b1, 1'b0);
    step();
    idle();
    wb_data = 16'hBEEF;
    #1;
`ifdef FWD_WB_BYPASS_EN
    check("d2_sel", 32'(fwd_sel), 32'h8);
    check("d2_data", fwd_data, 32'hBEEF_0000);
`else
    check("d2_sel", 32'(fwd_sel), 32'h0);
    check("d2_data", fwd_data, 32'h0);
`endif

    // load-use on r2
    issue(3'd0, 3'd0, 2'b00, 3'd2, 1'b1, 1'b1);
    step();
    issue(3'd2, 3'd0, 2'b01, 3'd7, 1'b1, 1'b0);
    #1 check("lu_stall1", 32'(stall), 32'h1);
    step();
    check("lu_bubble", 32'(fwd_sel), 32'h0);
`ifdef FWD_WB_BYPASS_EN
    check("lu_release", 32'(stall), 32'h0);
    step();
    idle();
    wb_data = 16'h5A5A;
    #1;
    check("lu_sel", 32'(fwd_sel), 32'h2);
    check("lu_data", fwd_data, 32'h0000_5A5A);
`else
    check("lu_stall2", 32'(stall), 32'h1);
    step();
    check("lu_release", 32'(stall), 32'h0);
    step();
    idle();
    #1;
    check("lu_sel", 32'(fwd_sel), 32'h0);
    check("lu_data", fwd_data, 32'h0);
`endif

    // MEM over WB priority on r4
    issue(3'd0, 3'd0, 2'b00, 3'd4, 1'b1, 1'b0);
    step();
    issue(3'd0, 3'd0, 2'b00, 3'd4, 1'b1, 1'b0);
    step();
    issue(3'd4, 3'd4, 2'b11, 3'd7, 1'b1, 1'b0);
    step();
    idle();
    mem_data = 16'h1111;
    wb_data  = 16'h2222;
    #1;
    check("prio_sel", 32'(fwd_sel), 32'h5);
    check("prio_data", fwd_data, 32'h1111_1111);

    // r0 is never forwarded or stalled on
    issue(3'd0, 3'd0, 2'b00, 3'd0, 1'b1, 1'b1);
    step();
    issue(3'd0, 3'd0, 2'b01, 3'd7, 1'b1, 1'b0);
    #1 check("r0_stall", 32'(stall), 32'h0);
    step();
    idle();
    #1;
    check("r0_sel", 32'(fwd_sel), 32'h0);
    check("r0_data", fwd_data, 32'h0);

    // flushed r6 writer must not forward
    issue(3'd0, 3'd0, 2'b00, 3'd6, 1'b1, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    issue(3'd6, 3'd0, 2'b01, 3'd7, 1'b1, 1'b0);
    step();
    idle();
    #1 check("flush_sel", 32'(fwd_sel), 32'h0);

    // flush and stall together
    issue(3'd0, 3'd0, 2'b00, 3'd2, 1'b1, 1'b1);
    step();
    issue(3'd2, 3'd0, 2'b01, 3'd7, 1'b1, 1'b0);
    flush = 1'b1;
    #1 check("flush_stall", 32'(stall), 32'h1);
    step();
    flush = 1'b0;
    idle();
    #1 check("flush_bubble", 32'(fwd_valid), 32'h0);
    repeat (3) step();

    // reset in the middle of a stall
    issue(3'd0, 3'd0, 2'b00, 3'd1, 1'b1, 1'b1);
    step();
    issue(3'd1, 3'd0, 2'b01, 3'd7, 1'b1, 1'b0);
    #1 check("mid_stall", 32'(stall), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_stall", 32'(stall), 32'h0);
    check("mid_rst_sel", 32'(fwd_sel), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("post_rst_stall", 32'(stall), 32'h0);
    step();
    idle();
    #1 check("post_rst_sel", 32'(fwd_sel), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
